// File: rtl/clock_divider_ctrl.sv
// Runtime-programmable clock divider with glitch-free ratio changes and start/stop at period boundaries.
// Optional macro CLKDIV_PERIOD_CNT_EN adds a saturating period counter output.
module clock_divider_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic             err
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             running_q, running_d;

    logic             accept;
    logic             goodReq;
    logic             lastCount;
    logic [CNT_W-1:0] countInc;
    logic [CNT_W-1:0] highLen;

    assign div_ready = (state_q != PEND);
    assign accept    = div_valid && div_ready;
    assign goodReq   = accept && (div_val >= CNT_W'(2));
    assign lastCount = (count_q == cur_div_q - CNT_W'(1));
    assign countInc  = count_q + CNT_W'(1);
    // High phase gets the extra cycle for odd ratios.
    assign highLen   = cur_div_q - (cur_div_q >> 1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        clk_out_d  = 1'b0;
        tick_d     = 1'b0;
        err_d      = accept && !goodReq;

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (goodReq) begin
                    cur_div_d = div_val;
                end
                if (enable) begin
                    state_d   = RUN;
                    clk_out_d = 1'b1;
                    tick_d    = 1'b1;
                end
            end
            RUN: begin
                if (lastCount) begin
                    count_d = '0;
                    if (enable) begin
                        clk_out_d = 1'b1;
                        tick_d    = 1'b1;
                        if (goodReq) begin
                            pend_div_d = div_val;
                            state_d    = PEND;
                        end
                    end else begin
                        // Stopping anyway, so a request on this edge can load directly.
                        state_d = IDLE;
                        if (goodReq) begin
                            cur_div_d = div_val;
                        end
                    end
                end else begin
                    count_d   = countInc;
                    clk_out_d = (countInc < highLen);
                    if (goodReq) begin
                        pend_div_d = div_val;
                        state_d    = PEND;
                    end
                end
            end
            PEND: begin
                if (lastCount) begin
                    count_d   = '0;
                    cur_div_d = pend_div_q;
                    if (enable) begin
                        state_d   = RUN;
                        clk_out_d = 1'b1;
                        tick_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    count_d   = countInc;
                    clk_out_d = (countInc < highLen);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        running_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            cur_div_q  <= CNT_W'(DEFAULT_DIV);
            pend_div_q <= '0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
            running_q  <= running_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign err     = err_q;
    assign running = running_q;

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] period_cnt_q;

    // A ratio change restarts the count; a tick on that same edge is the first period of the new ratio.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_q <= 16'd0;
        end else if (cur_div_d != cur_div_q) begin
            period_cnt_q <= tick_d ? 16'd1 : 16'd0;
        end else if (tick_d && (period_cnt_q != 16'hFFFF)) begin
            period_cnt_q <= period_cnt_q + 16'd1;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed self-checking bench for clock_divider_ctrl; period_cnt checks follow CLKDIV_PERIOD_CNT_EN.
module tb_clock_divider_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] div_val;
    logic       div_valid;
    logic       div_ready;
    logic       clk_out;
    logic       tick;
    logic       running;
    logic       err;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    int nAsserts;
    int nFails;

    clock_divider_ctrl #(
        .CNT_W      (8),
        .DEFAULT_DIV(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .div_val   (div_val),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running),
        .err       (err)
`ifdef CLKDIV_PERIOD_CNT_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic en, input logic valid, input logic [7:0] val);
        enable    = en;
        div_valid = valid;
        div_val   = val;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Each string holds one expected bit per cycle, first cycle leftmost.
    task automatic checkWave(input string tag, input int n, input string expClk, input string expTick,
                             input string expErr, input string expReady);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            checkOutput($sformatf("%s[%0d].clk", tag, i), 16'(clk_out), 16'(expClk[i] == "1"));
            checkOutput($sformatf("%s[%0d].tick", tag, i), 16'(tick), 16'(expTick[i] == "1"));
            checkOutput($sformatf("%s[%0d].err", tag, i), 16'(err), 16'(expErr[i] == "1"));
            checkOutput($sformatf("%s[%0d].ready", tag, i), 16'(div_ready), 16'(expReady[i] == "1"));
        end
    endtask

    initial begin
        nAsserts = 0;
        nFails   = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd0);

        #12;
        checkOutput("rst_clk", 16'(clk_out), 16'd0);
        checkOutput("rst_tick", 16'(tick), 16'd0);
        checkOutput("rst_err", 16'(err), 16'd0);
        checkOutput("rst_running", 16'(running), 16'd0);
        checkOutput("rst_ready", 16'(div_ready), 16'd1);
`ifdef CLKDIV_PERIOD_CNT_EN
        checkOutput("rst_pcnt", period_cnt, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("idle_clk", 16'(clk_out), 16'd0);
        checkOutput("idle_running", 16'(running), 16'd0);

        // Default ratio 4 straight out of reset, then stop.
        applyStimulus(1'b1, 1'b0, 8'd0);
        checkWave("div4", 8, "11001100", "10001000", "00000000", "11111111");
        checkOutput("div4_running", 16'(running), 16'd1);
        applyStimulus(1'b0, 1'b0, 8'd0);
        checkWave("stop4", 3, "000", "000", "000", "111");
        checkOutput("stop4_running", 16'(running), 16'd0);

        // Odd ratio loaded while idle.
        applyStimulus(1'b0, 1'b1, 8'd5);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 8'd0);
        checkOutput("load5_clk", 16'(clk_out), 16'd0);
        checkOutput("load5_running", 16'(running), 16'd0);
        applyStimulus(1'b1, 1'b0, 8'd0);
        checkWave("div5", 12, "111001110011", "100001000010", "000000000000", "111111111111");
        applyStimulus(1'b0, 1'b0, 8'd0);
        checkWave("stop5", 4, "1000", "0000", "0000", "1111");
        checkOutput("stop5_running", 16'(running), 16'd0);

        // Request and enable on the same edge: N=8 used for the first period.
        applyStimulus(1'b1, 1'b1, 8'd8);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'd0);
        checkOutput("div8_start_clk", 16'(clk_out), 16'd1);
        checkOutput("div8_start_tick", 16'(tick), 16'd1);
        checkOutput("div8_start_running", 16'(running), 16'd1);
        checkWave("div8a", 2, "11", "00", "00", "11");

        // Change to N=3 at count 2; old period completes 4/4.
        applyStimulus(1'b1, 1'b1, 8'd3);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'd0);
        checkOutput("pend3_ready", 16'(div_ready), 16'd0);
        checkOutput("pend3_clk", 16'(clk_out), 16'd1);
        checkOutput("pend3_tick", 16'(tick), 16'd0);
        checkOutput("pend3_err", 16'(err), 16'd0);
        checkWave("div8to3", 10, "0000110110", "0000100100", "0000000000", "0000111111");

        // Request on a wrap edge: PEND runs one full N=3 period, then N=6.
        applyStimulus(1'b1, 1'b1, 8'd6);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'd0);
        checkOutput("pend6_clk", 16'(clk_out), 16'd1);
        checkOutput("pend6_tick", 16'(tick), 16'd1);
        checkOutput("pend6_ready", 16'(div_ready), 16'd0);
        checkWave("div3to6", 10, "1011100011", "0010000010", "0000000000", "0011111111");

        // Drop enable at count 1 of N=6: period finishes 3/3.
        applyStimulus(1'b0, 1'b0, 8'd0);
        checkWave("stop6a", 4, "1000", "0000", "0000", "1111");
        checkOutput("stop6a_running", 16'(running), 16'd1);
        checkWave("stop6b", 2, "00", "00", "00", "11");
        checkOutput("stop6b_running", 16'(running), 16'd0);
        applyStimulus(1'b1, 1'b0, 8'd0);
        nextCycle();
        checkOutput("restart_clk", 16'(clk_out), 16'd1);
        checkOutput("restart_tick", 16'(tick), 16'd1);
        checkOutput("restart_running", 16'(running), 16'd1);

        // Back to N=4 for the invalid-request checks.
        applyStimulus(1'b1, 1'b1, 8'd4);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'd0);
        checkOutput("pend4_ready", 16'(div_ready), 16'd0);
        checkOutput("pend4_clk", 16'(clk_out), 16'd1);
        checkOutput("pend4_tick", 16'(tick), 16'd0);
        checkWave("div6to4", 5, "10001", "00001", "00000", "00001");

        applyStimulus(1'b1, 1'b1, 8'd1);
        nextCycle();
        checkOutput("bad1_err", 16'(err), 16'd1);
        checkOutput("bad1_ready", 16'(div_ready), 16'd1);
        checkOutput("bad1_clk", 16'(clk_out), 16'd1);
        checkOutput("bad1_tick", 16'(tick), 16'd0);
        applyStimulus(1'b1, 1'b1, 8'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'd0);
        checkOutput("bad0_err", 16'(err), 16'd1);
        checkOutput("bad0_ready", 16'(div_ready), 16'd1);
        checkOutput("bad0_clk", 16'(clk_out), 16'd0);
        checkWave("bad_after", 6, "011001", "010001", "000000", "111111");

        // Maximum ratio N=255: full period with no counter overflow.
        applyStimulus(1'b1, 1'b1, 8'd255);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'd0);
        checkOutput("pend255_ready", 16'(div_ready), 16'd0);
        checkOutput("pend255_clk", 16'(clk_out), 16'd1);
        checkWave("div4to255", 3, "001", "001", "000", "001");
        for (int c = 1; c < 255; c++) begin
            nextCycle();
            checkOutput($sformatf("div255[%0d].clk", c), 16'(clk_out), 16'(c < 128));
            checkOutput($sformatf("div255[%0d].tick", c), 16'(tick), 16'd0);
        end
        nextCycle();
        checkOutput("div255_wrap_clk", 16'(clk_out), 16'd1);
        checkOutput("div255_wrap_tick", 16'(tick), 16'd1);
        repeat (5) nextCycle();
        checkOutput("div255_high_clk", 16'(clk_out), 16'd1);

        // Asynchronous reset in the middle of the high phase.
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        checkOutput("arst_clk", 16'(clk_out), 16'd0);
        checkOutput("arst_tick", 16'(tick), 16'd0);
        checkOutput("arst_running", 16'(running), 16'd0);
        checkOutput("arst_ready", 16'(div_ready), 16'd1);
        checkOutput("arst_err", 16'(err), 16'd0);
`ifdef CLKDIV_PERIOD_CNT_EN
        checkOutput("arst_pcnt", period_cnt, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("arst_idle_clk", 16'(clk_out), 16'd0);
        checkOutput("arst_idle_running", 16'(running), 16'd0);

        applyStimulus(1'b1, 1'b0, 8'd0);
        checkWave("post_rst_a", 1, "1", "1", "0", "1");
`ifdef CLKDIV_PERIOD_CNT_EN
        checkOutput("pcnt_1", period_cnt, 16'd1);
`endif
        checkWave("post_rst_b", 4, "1001", "0001", "0000", "1111");
`ifdef CLKDIV_PERIOD_CNT_EN
        checkOutput("pcnt_2", period_cnt, 16'd2);
`endif
        checkWave("post_rst_c", 4, "1001", "0001", "0000", "1111");
`ifdef CLKDIV_PERIOD_CNT_EN
        checkOutput("pcnt_3", period_cnt, 16'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/clock_divider_ctrl.md
Name: clock_divider_ctrl

Overview:
- Runtime-programmable clock-divider controller.
- Accepts divide-ratio updates over a valid/ready handshake and starts/stops the divided output on request.
- Applies every change only at a period boundary, so clk_out never shows a runt pulse.
- Sits between a config/CSR block and any logic that needs a reprogrammable slow clock or a tick enable.

Parameters:
- CNT_W, 8, width of the divide ratio and the internal counter.
- DEFAULT_DIV, 4, ratio loaded at reset; must be >= 2 and < 2**CNT_W.

Ports:
- clk  input  1  system clock; every flop is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  level; 1 = run the divider, 0 = stop at the next period end.
- div_val  input  CNT_W  requested divide ratio N.
- div_valid  input  1  request qualifier for div_val.
- div_ready  output  1  controller can accept a request this cycle.
- clk_out  output  1  registered divided clock.
- tick  output  1  one-cycle pulse in the first cycle of each clk_out high phase.
- running  output  1  state is RUN or PEND.
- err  output  1  one-cycle pulse: an accepted request had N < 2.

Behaviour:
- Reset (rst_n=0, async) sets:
  - state=IDLE, count=0, cur_div=DEFAULT_DIV, pend_div=0
  - clk_out=0, tick=0, err=0, running=0, div_ready=1
- Handshake:
  - A transfer occurs on a rising edge with div_valid & div_ready.
  - div_ready = 1 in IDLE and RUN; 0 in PEND.
  - A request with N < 2 completes the handshake, pulses err on the next cycle, and leaves cur_div and state unchanged.
- Duty cycle for cur_div = N:
  - High phase = N - floor(N/2) cycles, low phase = floor(N/2) cycles. Even N gives 50% duty; odd N is high-biased by one cycle (N=5: 3 high, 2 low).
  - clk_out = 1 when count < N - floor(N/2), and is registered alongside count.
  - count runs 0..N-1 and wraps to 0.
- IDLE (count=0, clk_out=0):
  - A valid request loads cur_div directly.
  - enable=1 sampled at edge k moves to RUN. After edge k: count=0, clk_out=1, tick=1.
  - If a request and enable arrive on the same edge, the new N is used for the very first period.
- RUN:
  - The counter advances every cycle.
  - A valid request latches pend_div and moves to PEND.
  - At count==N-1 with enable=0: go to IDLE. After that edge, clk_out=0 and count=0. The last period is always completed.
- PEND:
  - The counter keeps running with the old N.
  - At count==N-1: cur_div <= pend_div, count <= 0. The new period starts on that same edge (clk_out=1, tick=1), then return to RUN.
  - If enable=0 at that boundary: still load cur_div, then go to IDLE.
- tick is asserted exactly when count transitions to 0 while staying in RUN or PEND. It is never asserted in IDLE.
- running is a registered state decode.
- Reset mid-period drops clk_out to 0 immediately (async). This is the only permitted runt.
- N = 2**CNT_W - 1 must work with no counter overflow. Counter compares are on CNT_W bits.
- Requests with div_valid held high across a PEND window are accepted on the first edge after PEND exits to RUN.

Optional Feature:
- Macro CLKDIV_PERIOD_CNT_EN.
- When defined:
  - Adds output period_cnt [15:0], which increments on every tick and saturates at 16'hFFFF.
  - Cleared by reset and on every cur_div change.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset default: rst_n low then high, enable=1 -> clk_out period 4 cycles (2 high/2 low), first tick one cycle after enable is sampled, running=1.
- Odd ratio: in IDLE, write N=5, then enable=1 -> repeating 3 high/2 low, tick every 5 cycles, no extra pulses.
- Glitch-free change: running N=8, write N=3 at count=2 -> div_ready=0 until count 7; the old period completes 4/4; next periods are 2/1; exactly one err-free transfer.
- Stop: running N=6, drop enable at count=1 -> the period finishes (3 high/3 low), then clk_out stays 0 and running=0; re-enable restarts with clk_out=1 on the next edge.
- Invalid request: write N=1 and N=0 while running N=4 -> err pulses once per request, period stays 4, div_ready never drops.
- Async reset mid-high-phase with N=255 -> clk_out=0 and count=0 immediately; after release, cur_div=4. With CLKDIV_PERIOD_CNT_EN defined, period_cnt=0 after reset and counts 1,2,3 over 3 periods.
